sync_fifo_cfg: RTL and testbench
================================

Name: sync_fifo_cfg

Overview:
Parametrised single-clock FIFO, successor to the basic sync FIFO. Adds:
- selectable first-word-fall-through (FWFT) or standard registered-read mode
- registered read-data output
- runtime-programmable almost-full/almost-empty thresholds
- occupancy count output
- synchronous flush
- sticky overflow/underflow error flags with clear

It buffers data between LCB datapath stages where producer/consumer rates differ and software monitors fill level.

Parameters:
DATA_WIDTH, 16, word width in bits.
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2^ADDR_WIDTH, total capacity DEPTH words.
FWFT, 1, 1 = first-word-fall-through read mode, 0 = standard read mode (data one cycle after rd_en).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous clear of contents, pointers and count.
wr_data  in  DATA_WIDTH  write data.
wr_en  in  1  write request.
full  out  1  count == DEPTH.
almost_full  out  1  count >= af_thresh.
rd_en  in  1  read request / pop.
rd_data  out  DATA_WIDTH  registered read data.
rd_valid  out  1  rd_data holds a valid word (FWFT: head present; standard: one-cycle strobe).
empty  out  1  no word available to read.
almost_empty  out  1  count <= ae_thresh.
count  out  ADDR_WIDTH+1  words held, 0..DEPTH.
af_thresh  in  ADDR_WIDTH+1  almost-full threshold, sampled every cycle.
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold, sampled every cycle.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.
err_clr  in  1  clears overflow/underflow.

Behaviour:
Reset (rst_n low, async, held):
- pointers, count and rd_data = 0; rd_valid = 0; empty = 1; full = 0; overflow = underflow = 0.
- almost_full = (af_thresh == 0); almost_empty = 1.

Accept rules:
- Write accepted iff wr_en && !full, evaluated on pre-edge state. A read in the same cycle does not free space for the write.
- Read accepted iff rd_en && !empty.
- Unaccepted requests change no state except error flags.

count:
- Registered; +1 on accepted write, -1 on accepted read, unchanged if both or neither.
- FWFT: count includes the word in the output register.

Flags:
- full, almost_full, almost_empty are combinational from the count register and the threshold inputs.
- Threshold compares are unsigned, ADDR_WIDTH+1 bits.

FWFT=1:
- Output register is loaded from memory whenever it is empty or being popped and memory holds data.
- A write into a totally empty FIFO appears on rd_data with rd_valid=1 on the cycle after the write edge (latency 1).
- empty = !rd_valid.
- Pop with more data behind: next word appears on the following cycle with no bubble; rd_valid stays 1.
- rd_data holds its last value when rd_valid = 0.

FWFT=0:
- empty = (count == 0).
- Accepted read at edge N: rd_data = head word and rd_valid = 1 for exactly cycle N+1; otherwise rd_valid = 0 and rd_data holds.
- Back-to-back reads give one word per cycle.

Error flags:
- overflow sets on wr_en && full; underflow sets on rd_en && empty.
- Both hold until err_clr. If set and err_clr coincide, set wins.

flush:
- Next edge: pointers and count = 0, rd_valid = 0, empty = 1.
- wr_en/rd_en in the flush cycle are ignored and do not set error flags.
- Error flags and rd_data are unaffected.

Pointers:
- ADDR_WIDTH+1 bit binary; wrap modulo 2*DEPTH with no special casing.
- Memory is indexed by the low ADDR_WIDTH bits.

Reset mid-operation: immediate async return to the reset state; in-flight words are discarded.

Test Plan:
- FWFT=1, DEPTH=16: write 0xA5A5 to empty FIFO -> next cycle rd_valid=1, rd_data=0xA5A5, empty=0, count=1. rd_en one cycle -> empty=1, count=0, underflow=0.
- FWFT=1: write 16 words 0..15 -> full=1, count=16. 17th write -> data discarded, overflow=1. Read all with continuous rd_en -> values 0..15 in order, no bubbles, then empty=1.
- FWFT=0: write 3 words, then rd_en for 3 cycles -> rd_valid high cycles 1-3 after first rd_en, data in order, count 3->0. Extra rd_en -> underflow=1, rd_valid=0.
- Full with simultaneous rd_en and wr_en -> read accepted, write rejected, count 16->15, overflow=1. err_clr asserted in a cycle with no new error -> both flags 0.
- af_thresh=12, ae_thresh=3: fill 0->16 -> almost_empty=1 for count<=3; almost_full=1 from count 12. Change af_thresh to 14 at count 13 -> almost_full drops the same cycle.
- 8 words queued, assert flush together with wr_en -> next cycle count=0, empty=1, no overflow. rst_n pulse mid-burst -> all outputs at reset values while low.

Source files
------------

// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO with selectable first-word-fall-through or registered-read
// mode, programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module sync_fifo_cfg #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  load_out;
  logic                  clear_valid;
  logic [DATA_WIDTH-1:0] load_data;

  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign count        = count_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read never frees space for a same-cycle write: both use pre-edge flags.
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  generate
    if (FWFT) begin : g_fwft
      logic mem_empty;

      // The output register counts as storage, so "empty" means no head word.
      // When memory is empty an incoming write bypasses straight into the
      // output register, giving single-cycle latency into an idle FIFO.
      assign mem_empty   = (wr_ptr == rd_ptr);
      assign empty       = !rd_valid_q;
      assign load_out    = !flush && (!rd_valid_q || rd_acc) && (!mem_empty || wr_acc);
      assign load_data   = mem_empty ? wr_data : mem[rd_ptr[ADDR_WIDTH-1:0]];
      assign clear_valid = rd_acc;

      assert property (@(posedge clk) disable iff (!rst_n)
        count_q == (wr_ptr - rd_ptr) + (ADDR_WIDTH+1)'(rd_valid_q));
    end else begin : g_std
      assign empty       = (count_q == '0);
      assign load_out    = rd_acc;
      assign load_data   = mem[rd_ptr[ADDR_WIDTH-1:0]];
      assign clear_valid = 1'b1;

      assert property (@(posedge clk) disable iff (!rst_n)
        count_q == (wr_ptr - rd_ptr));
    end
  endgenerate

  assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH_CNT);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Pointers wrap naturally modulo 2*DEPTH; the read pointer advances on every
  // word moved out of memory, including a bypassed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (load_out) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (flush) begin
      rd_valid_q <= 1'b0;
    end else if (load_out) begin
      rd_data_q  <= load_data;
      rd_valid_q <= 1'b1;
    end else if (clear_valid) begin
      rd_valid_q <= 1'b0;
    end
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (wr_en && full && !flush) || (overflow_q && !err_clr);
      underflow_q <= (rd_en && empty && !flush) || (underflow_q && !err_clr);
    end
  end

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Directed bench for sync_fifo_cfg: one FWFT instance and one standard-mode
// instance share all inputs; each phase checks the instance it targets.
module tb_sync_fifo_cfg;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          rd_en;
  logic [AW:0]   af_thresh;
  logic [AW:0]   ae_thresh;
  logic          err_clr;

  logic          f_full, f_almost_full, f_rd_valid, f_empty, f_almost_empty;
  logic          f_overflow, f_underflow;
  logic [DW-1:0] f_rd_data;
  logic [AW:0]   f_count;

  logic          s_full, s_almost_full, s_rd_valid, s_empty, s_almost_empty;
  logic          s_overflow, s_underflow;
  logic [DW-1:0] s_rd_data;
  logic [AW:0]   s_count;

  int num_checks = 0;
  int num_errors = 0;

  sync_fifo_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .full(f_full), .almost_full(f_almost_full), .rd_en(rd_en), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_almost_empty),
    .count(f_count), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(f_overflow), .underflow(f_underflow), .err_clr(err_clr)
  );

  sync_fifo_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .full(s_full), .almost_full(s_almost_full), .rd_en(rd_en), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_almost_empty),
    .count(s_count), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(s_overflow), .underflow(s_underflow), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of requests, then lets outputs settle just after the edge.
  task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    err_clr = 1'b0; af_thresh = '0; ae_thresh = 5'd3;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_count", f_count, 0);
    checkOutput("rst_empty", f_empty, 1);
    checkOutput("rst_full", f_full, 0);
    checkOutput("rst_rd_valid", f_rd_valid, 0);
    checkOutput("rst_rd_data", f_rd_data, 0);
    checkOutput("rst_af_thr0", f_almost_full, 1);
    checkOutput("rst_ae", f_almost_empty, 1);
    checkOutput("rst_ovf", f_overflow, 0);
    checkOutput("rst_s_empty", s_empty, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    af_thresh = 5'd12;
    #1;
    checkOutput("af_thr12_empty", f_almost_full, 0);

    // FWFT: single word latency and pop
    applyStimulus(1'b1, 16'hA5A5, 1'b0);
    checkOutput("fwft_lat_valid", f_rd_valid, 1);
    checkOutput("fwft_lat_data", f_rd_data, 16'hA5A5);
    checkOutput("fwft_lat_empty", f_empty, 0);
    checkOutput("fwft_lat_count", f_count, 1);
    checkOutput("std_no_valid", s_rd_valid, 0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fwft_pop_empty", f_empty, 1);
    checkOutput("fwft_pop_count", f_count, 0);
    checkOutput("fwft_pop_udf", f_underflow, 0);
    checkOutput("std_pop_valid", s_rd_valid, 1);
    checkOutput("std_pop_data", s_rd_data, 16'hA5A5);
    tick();
    checkOutput("std_strobe_end", s_rd_valid, 0);
    checkOutput("std_data_hold", s_rd_data, 16'hA5A5);

    // FWFT: fill to full, watching thresholds and a live threshold change
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0);
      checkOutput("fill_count", f_count, i + 1);
      checkOutput("fill_ae", f_almost_empty, (i + 1) <= 3);
      checkOutput("fill_af", f_almost_full, (i + 1) >= int'(af_thresh));
      if (i + 1 == 13) begin
        af_thresh = 5'd14;
        #1;
        checkOutput("af_thr_change", f_almost_full, 0);
      end
    end
    checkOutput("fill_full", f_full, 1);
    checkOutput("fill_head", f_rd_data, 0);
    applyStimulus(1'b1, 16'hDEAD, 1'b0);
    checkOutput("ovf_set", f_overflow, 1);
    checkOutput("ovf_count", f_count, 16);
    checkOutput("ovf_head", f_rd_data, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("clr_ovf", f_overflow, 0);
    checkOutput("clr_udf", f_underflow, 0);

    // Full with simultaneous read and write: only the read is taken
    applyStimulus(1'b1, 16'hBEEF, 1'b1);
    checkOutput("rw_full_count", f_count, 15);
    checkOutput("rw_full_ovf", f_overflow, 1);
    checkOutput("rw_full_notfull", f_full, 0);
    checkOutput("rw_full_head", f_rd_data, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("clr2_ovf", f_overflow, 0);
    checkOutput("clr2_udf", f_underflow, 0);

    // Continuous drain: one word per cycle, no bubbles
    rd_en = 1'b1;
    for (int k = 1; k < 16; k++) begin
      checkOutput("drain_data", f_rd_data, k);
      checkOutput("drain_valid", f_rd_valid, 1);
      tick();
    end
    rd_en = 1'b0;
    checkOutput("drain_empty", f_empty, 1);
    checkOutput("drain_count", f_count, 0);
    checkOutput("drain_udf", f_underflow, 0);
    checkOutput("drain_hold", f_rd_data, 15);
    checkOutput("drain_valid0", f_rd_valid, 0);

    // Standard mode: three words, three reads, then one read too many
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(16'h100 + i), 1'b0);
    checkOutput("std_count3", s_count, 3);
    checkOutput("std_empty0", s_empty, 0);
    checkOutput("std_valid0", s_rd_valid, 0);
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("std_rd_valid", s_rd_valid, 1);
      checkOutput("std_rd_data", s_rd_data, 16'h100 + k);
      checkOutput("std_rd_count", s_count, 2 - k);
    end
    tick();
    rd_en = 1'b0;
    checkOutput("std_udf", s_underflow, 1);
    checkOutput("std_udf_valid", s_rd_valid, 0);
    checkOutput("std_udf_hold", s_rd_data, 16'h102);
    checkOutput("std_empty1", s_empty, 1);

    // Flush with a write pending; sticky underflow must survive it
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'(16'h200 + i), 1'b0);
    checkOutput("pre_flush_count", f_count, 8);
    flush = 1'b1;
    applyStimulus(1'b1, 16'h300, 1'b0);
    flush = 1'b0;
    checkOutput("flush_count", f_count, 0);
    checkOutput("flush_empty", f_empty, 1);
    checkOutput("flush_valid", f_rd_valid, 0);
    checkOutput("flush_ovf", f_overflow, 0);
    checkOutput("flush_udf_kept", f_underflow, 1);
    checkOutput("flush_data_kept", f_rd_data, 16'h200);
    checkOutput("flush_s_count", s_count, 0);

    // Set wins over clear, then clear alone
    err_clr = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("set_wins_udf", f_underflow, 1);
    tick();
    err_clr = 1'b0;
    checkOutput("clr3_udf", f_underflow, 0);

    // Requests during flush are ignored and raise no error
    flush = 1'b1;
    applyStimulus(1'b1, 16'h3333, 1'b1);
    flush = 1'b0;
    checkOutput("flush_rd_noudf", f_underflow, 0);
    checkOutput("flush_wr_ignored", f_count, 0);
    checkOutput("flush_wr_novalid", f_rd_valid, 0);

    // Async reset in the middle of a write burst
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pre_rst_udf", f_underflow, 1);
    wr_en = 1'b1;
    wr_data = 16'h400;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("burst_count", f_count, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_count", f_count, 0);
    checkOutput("mid_rst_empty", f_empty, 1);
    checkOutput("mid_rst_valid", f_rd_valid, 0);
    checkOutput("mid_rst_data", f_rd_data, 0);
    checkOutput("mid_rst_full", f_full, 0);
    checkOutput("mid_rst_ae", f_almost_empty, 1);
    checkOutput("mid_rst_af", f_almost_full, 0);
    checkOutput("mid_rst_udf", f_underflow, 0);
    checkOutput("mid_rst_s_data", s_rd_data, 0);
    tick();
    checkOutput("rst_held_count", f_count, 0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
